// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared types and constants for the register-bank command driver
package regbank_pkg;
  localparam int W     = 8;
  localparam int AW    = 3;
  localparam int NREGS = 8;

  // Encodings 5-7 are deliberately left out; the driver rejects them as illegal.
  typedef enum logic [2:0] {
    OP_READ  = 3'd0,
    OP_WRITE = 3'd1,
    OP_ADD   = 3'd2,
    OP_COPY  = 3'd3,
    OP_SWAP  = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_WR,
    S_WR2,
    S_SETTLE,
    S_RESP
  } state_e;
endpackage

// File: rtl/register8_bank_v2.sv
// rtl/register8_bank_v2.sv - 8-entry register bank, X0 reads zero, writes land two edges after we3
module register8_bank_v2 #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we3,
  input  logic [AW-1:0] wa3,
  input  logic [W-1:0]  wd3,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [W-1:0]  rd1,
  output logic [W-1:0]  rd2
);
  logic [W-1:0]  regs [0:(1<<AW)-1];
  logic          st_we;
  logic [AW-1:0] st_a;
  logic [W-1:0]  st_d;

  // Writes are staged for one edge before reaching the array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_we <= 1'b0;
      st_a  <= '0;
      st_d  <= '0;
      for (int i = 0; i < (1<<AW); i++) regs[i] <= '0;
    end else begin
      st_we <= we3;
      st_a  <= wa3;
      st_d  <= wd3;
      if (st_we && st_a != '0) regs[st_a] <= st_d;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];
endmodule

// File: rtl/regbank_driver.sv
// rtl/regbank_driver.sv - executes READ/WRITE/ADD/COPY/SWAP commands against an external register bank
module regbank_driver #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic [AW-1:0] cmd_rd,
  input  logic [W-1:0]  cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [W-1:0]  rsp_data,
  output logic          rsp_err,
  output logic          rsp_carry,
  output logic          we3,
  output logic [AW-1:0] wa3,
  output logic [W-1:0]  wd3,
  output logic [AW-1:0] ra1,
  output logic [AW-1:0] ra2,
  input  logic [W-1:0]  rd1,
  input  logic [W-1:0]  rd2
);
  import regbank_pkg::*;

  state_e        state, state_n;
  logic [2:0]    op_q;
  logic [AW-1:0] ra_q, rb_q, rd_q;
  logic [W-1:0]  data_q, op_a, op_b;
  logic          exec_err;
  logic [W-1:0]  exec_val;
  logic [W:0]    settle_val;

  // First-write value with the ADD carry in the top bit.
  function automatic logic [W:0] write_value(input logic [2:0] op, input logic [W-1:0] imm,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] r;
    r = '0;
    case (op)
      OP_WRITE: r = {1'b0, imm};
      OP_ADD:   r = {1'b0, a} + {1'b0, b};
      OP_COPY:  r = {1'b0, a};
      OP_SWAP:  r = {1'b0, b};
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Register 0 is read-only zero, so any write aimed at it is refused up front.
  always_comb begin
    exec_err = (op_q > OP_SWAP)
             || ((op_q == OP_WRITE || op_q == OP_ADD || op_q == OP_COPY) && rd_q == '0)
             || (op_q == OP_SWAP && (ra_q == '0 || rb_q == '0));
    exec_val   = W'(write_value(op_q, data_q, rd1, rd2));
    settle_val = write_value(op_q, data_q, op_a, op_b);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (cmd_valid) state_n = S_EXEC;
      S_EXEC:   state_n = (op_q == OP_READ || exec_err) ? S_RESP : S_WR;
      S_WR:     state_n = (op_q == OP_SWAP) ? S_WR2 : S_SETTLE;
      S_WR2:    state_n = S_SETTLE;
      S_SETTLE: state_n = S_RESP;
      S_RESP:   if (rsp_ready) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = rst && (state == S_IDLE);
    rsp_valid = (state == S_RESP);
  end

  // Bank-side outputs are decided one edge ahead from state_n so they leave registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q <= '0; ra_q <= '0; rb_q <= '0; rd_q <= '0; data_q <= '0;
      op_a <= '0; op_b <= '0;
      rsp_data <= '0; rsp_err <= 1'b0; rsp_carry <= 1'b0;
      we3 <= 1'b0; wa3 <= '0; wd3 <= '0; ra1 <= '0; ra2 <= '0;
    end else begin
      if (state == S_IDLE && cmd_valid) begin
        op_q   <= cmd_op;
        ra_q   <= cmd_ra;
        rb_q   <= cmd_rb;
        rd_q   <= cmd_rd;
        data_q <= cmd_data;
        ra1    <= cmd_ra;
        ra2    <= cmd_rb;
      end
      if (state == S_EXEC) begin
        op_a      <= rd1;
        op_b      <= rd2;
        rsp_err   <= exec_err;
        rsp_carry <= 1'b0;
        rsp_data  <= (op_q == OP_READ) ? rd1 : '0;
      end
      we3 <= (state_n == S_WR) || (state_n == S_WR2);
      if (state_n == S_WR) begin
        wa3 <= (op_q == OP_SWAP) ? ra_q : rd_q;
        wd3 <= exec_val;
      end else if (state_n == S_WR2) begin
        wa3 <= rb_q;
        wd3 <= op_a;
      end
      if (state_n == S_SETTLE) begin
        rsp_data  <= settle_val[W-1:0];
        rsp_carry <= settle_val[W];
      end
    end
  end
endmodule

// File: tb/tb_regbank_driver.sv
// tb/tb_regbank_driver.sv - scoreboard bench for regbank_driver on register8_bank_v2
module tb_regbank_driver;
  import regbank_pkg::*;

  logic          clk;
  logic          rst, bank_rst;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_ra, cmd_rb, cmd_rd;
  logic [W-1:0]  cmd_data;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_carry;
  logic [W-1:0]  rsp_data;
  logic          we3;
  logic [AW-1:0] wa3, ra1, ra2;
  logic [W-1:0]  wd3, rd1, rd2;

  regbank_driver #(.W(W), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_carry(rsp_carry),
    .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2)
  );

  register8_bank_v2 #(.W(W), .AW(AW)) bank (
    .clk(clk), .rst(bank_rst), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    logic         carry;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           cmp_n = 0, fail_n = 0, cyc = 0, acc_cyc = 0, we_hits = 0, hs;
  logic         pend = 1'b0, forbid_we = 1'b0;
  logic [W-1:0] h_data;
  logic         h_err, h_carry;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each new response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) pend = 1'b0;
    else begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc + 1;
      if (forbid_we && we3) we_hits++;
      if (rsp_valid) begin
        if (!pend) begin
          pend = 1'b1; h_data = rsp_data; h_err = rsp_err; h_carry = rsp_carry;
          check("rsp_expected", 32'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_latency", cyc + 1 - acc_cyc, e.lat);
            check("rsp_data", rsp_data, e.data);
            check("rsp_err", rsp_err, e.err);
            check("rsp_carry", rsp_carry, e.carry);
          end
        end else begin
          check("rsp_stable", {rsp_data, rsp_err, rsp_carry}, {h_data, h_err, h_carry});
        end
        if (rsp_ready) pend = 1'b0;
      end
    end
  end

  task automatic issue(input logic [2:0] op, input int ra, input int rb, input int rd,
                       input int data, input bit want, input int ed, input bit ee,
                       input bit ec, input int lat);
    int n;
    exp_t e;
    if (want) begin
      e.data = W'(ed); e.err = ee; e.carry = ec; e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    cmd_op = op; cmd_ra = AW'(ra); cmd_rb = AW'(rb); cmd_rd = AW'(rd); cmd_data = W'(data);
    cmd_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 200);
    check("accept_in_time", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 200) begin @(negedge clk); n++; end
    check("drain_in_time", 32'(n < 200), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; bank_rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rd = '0; cmd_data = '0;
    #12;
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_we3", we3, 0);
    check("reset_rsp_data", rsp_data, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1; bank_rst = 1'b1;

    // Reset during the WR cycle of WRITE X2=0x77 must drop the write.
    issue(OP_WRITE, 0, 0, 2, 'h77, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    check("wr_cycle_we3", we3, 1);
    rst = 1'b0; #1;
    check("abort_we3", we3, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1; #1;
    check("release_cmd_ready", cmd_ready, 1);
    issue(OP_READ, 2, 0, 0, 0, 1, 'h00, 0, 0, 2);

    issue(OP_WRITE, 0, 0, 3, 'h5A, 1, 'h5A, 0, 0, 4);
    issue(OP_READ,  3, 0, 0, 0,    1, 'h5A, 0, 0, 2);

    issue(OP_WRITE, 0, 0, 1, 'hF0, 1, 'hF0, 0, 0, 4);
    issue(OP_WRITE, 0, 0, 2, 'h20, 1, 'h20, 0, 0, 4);
    issue(OP_ADD,   1, 2, 4, 0,    1, 'h10, 0, 1, 4);
    issue(OP_READ,  4, 0, 0, 0,    1, 'h10, 0, 0, 2);
    issue(OP_ADD,   3, 2, 7, 0,    1, 'h7A, 0, 0, 4);

    issue(OP_WRITE, 0, 0, 5, 'h11, 1, 'h11, 0, 0, 4);
    issue(OP_WRITE, 0, 0, 6, 'h22, 1, 'h22, 0, 0, 4);
    issue(OP_SWAP,  5, 6, 0, 0,    1, 'h22, 0, 0, 5);
    issue(OP_READ,  5, 0, 0, 0,    1, 'h22, 0, 0, 2);
    issue(OP_READ,  6, 0, 0, 0,    1, 'h11, 0, 0, 2);
    issue(OP_SWAP,  3, 3, 0, 0,    1, 'h5A, 0, 0, 5);
    issue(OP_READ,  3, 0, 0, 0,    1, 'h5A, 0, 0, 2);
    issue(OP_COPY,  6, 0, 7, 0,    1, 'h11, 0, 0, 4);
    issue(OP_READ,  7, 0, 0, 0,    1, 'h11, 0, 0, 2);
    drain();

    forbid_we = 1'b1;
    issue(OP_WRITE, 0, 0, 0, 'hFF, 1, 'h00, 1, 0, 2);
    issue(3'd7,     1, 2, 3, 'h33, 1, 'h00, 1, 0, 2);
    issue(OP_SWAP,  5, 0, 0, 0,    1, 'h00, 1, 0, 2);
    issue(OP_ADD,   1, 2, 0, 0,    1, 'h00, 1, 0, 2);
    drain();
    forbid_we = 1'b0;
    check("no_we3_on_errors", we_hits, 0);
    issue(OP_READ, 0, 0, 0, 0, 1, 'h00, 0, 0, 2);
    drain();

    // Backpressure: response held 10 cycles while a second command waits.
    rsp_ready = 1'b0;
    issue(OP_READ, 5, 0, 0, 0, 1, 'h22, 0, 0, 2);
    begin
      exp_t e;
      e.data = 'h11; e.err = 1'b0; e.carry = 1'b0; e.lat = 2;
      sb.push_back(e);
    end
    cmd_op = OP_READ; cmd_ra = 3'd6; cmd_rb = '0; cmd_rd = '0; cmd_data = '0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_cmd_ready", cmd_ready, 0);
    end
    check("stall_rsp_valid", rsp_valid, 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    hs = cyc + 1;
    @(negedge clk); @(negedge clk);
    check("ready_after_handshake", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("accept_cycle_after_handshake", acc_cyc, hs + 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end
endmodule

// File: doc/regbank_driver.md
REGBANK_DRIVER -- requirements
Module: regbank_driver

Interface
REQ-001 SHALL have parameter W, default 8, meaning data width of the bank.
REQ-002 SHALL have parameter AW, default 3, meaning register address width (8 registers).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port cmd_valid, input, 1, command offered.
REQ-006 SHALL have port cmd_ready, output, 1, command accepted when both cmd_valid and cmd_ready are high at a clk edge.
REQ-007 SHALL have port cmd_op, input, 3, opcode: 0 READ, 1 WRITE, 2 ADD, 3 COPY, 4 SWAP, 5-7 illegal.
REQ-008 SHALL have ports cmd_ra, cmd_rb, cmd_rd, input, AW each, meaning source A, source B and destination register.
REQ-009 SHALL have port cmd_data, input, W, meaning the immediate for WRITE.
REQ-010 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_data (output, W), rsp_err (output, 1) and rsp_carry (output, 1).
REQ-011 SHALL have bank-side ports we3 (output, 1), wa3 (output, AW), wd3 (output, W), ra1 (output, AW), ra2 (output, AW), rd1 (input, W) and rd2 (input, W), matching the 8x8 bank pinout.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, WR, WR2, SETTLE and RESP.
REQ-013 SHALL assert cmd_ready only in IDLE, and SHALL capture all cmd_* fields on acceptance and move to EXEC.
REQ-014 EXEC SHALL drive ra1=ra_q and ra2=rb_q, then latch rd1 into opA and rd2 into opB at the end of the cycle.
REQ-015 From EXEC: READ SHALL go to RESP with rsp_data=opA; an illegal op SHALL go to RESP with rsp_err=1 and no write.
REQ-016 From EXEC: a WRITE, ADD or COPY with rd_q=0, or a SWAP with ra_q=0 or rb_q=0, SHALL go to RESP with rsp_err=1 and no we3 (register 0 is read-only zero).
REQ-017 Otherwise, from EXEC the FSM SHALL go to WR.
REQ-018 WR SHALL assert we3 for exactly one cycle with wa3/wd3 as follows: WRITE rd_q/data_q; ADD rd_q/(opA+opB) mod 2^W; COPY rd_q/opA; SWAP ra_q/opB.
REQ-019 SWAP SHALL continue WR -> WR2; WR2 SHALL assert we3 for one cycle with wa3=rb_q and wd3=opA.
REQ-020 The last write cycle SHALL be followed by exactly one SETTLE cycle, covering the bank's 2-edge write-to-read latency, then RESP.
REQ-021 For ADD, rsp_carry SHALL be bit W of opA+opB and rsp_data the truncated sum; for WRITE/COPY rsp_data SHALL be the value written.
REQ-022 For SWAP, rsp_data SHALL be the new X[ra] and rsp_carry SHALL be 0 for non-ADD ops.
REQ-023 SWAP with ra_q==rb_q SHALL perform both writes, leaving the value unchanged.
REQ-024 RESP SHALL hold rsp_valid and rsp_data/err/carry stable until rsp_ready; on the handshake it SHALL return to IDLE, and no new command SHALL be accepted while a response is pending.
REQ-025 Latency from acceptance edge to rsp_valid: READ/error 2 cycles; WRITE/ADD/COPY 4 cycles; SWAP 5 cycles.
REQ-026 we3, wa3, wd3, ra1 and ra2 SHALL be register outputs (no combinational path from cmd_* to the bank); we3 SHALL be 0 outside WR/WR2.

Reset
REQ-027 While rst=0 all outputs SHALL be 0 (cmd_ready=0, rsp_valid=0, we3=0), state IDLE, opA/opB cleared.
REQ-028 Assertion of rst mid-operation SHALL abort immediately (asynchronously); any pending write or response SHALL be dropped, and cmd_ready=1 SHALL appear in the first cycle after release.

Structure
REQ-029 Package regbank_pkg SHALL hold the opcode enum, the FSM state enum, and constants W=8, AW=3, NREGS=8.
REQ-030 The block SHALL be a single module with no sub-module; the bench SHALL instantiate it against register8_bank_v2.

Verification
REQ-031 Reset then WRITE rd=3 data=0x5A, then READ ra=3 -> rsp_data=0x5A, rsp_err=0; write response 4 cycles after acceptance.
REQ-032 Load X1=0xF0, X2=0x20; ADD ra=1 rb=2 rd=4 -> rsp_data=0x10, rsp_carry=1; READ 4 -> 0x10.
REQ-033 X5=0x11, X6=0x22; SWAP ra=5 rb=6 -> rsp_data=0x22 after 5 cycles; READ 5 -> 0x22, READ 6 -> 0x11.
REQ-034 WRITE rd=0 data=0xFF, and op=7 -> rsp_err=1 after 2 cycles, we3 never high, READ 0 -> 0x00.
REQ-035 Hold rsp_ready=0 for 10 cycles with cmd_valid=1 -> rsp stable, cmd_ready=0; release -> next command accepted the cycle after the handshake.
REQ-036 Assert rst during the WR cycle of WRITE rd=2 data=0x77 -> we3 drops at once, no response; READ 2 after release -> 0x00.
